// File: rtl/minisys_pkg.sv
// Shared MiniSys-1A MEM-stage definitions: FSM encoding, load-type indices, MEM/WB bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minisys_pkg;

    // Memory-access FSM encoding
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Bit positions of the one-hot load-type vector
    localparam int LD_LB  = 0;
    localparam int LD_LBU = 1;
    localparam int LD_LH  = 2;
    localparam int LD_LHU = 3;
    localparam int LD_LW  = 4;
    localparam int LD_NUM = 5;

    // MEM/WB bundle field widths
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              mem2reg;
        logic              link;
        logic [REG_W-1:0]  writeReg;
        logic [DATA_W-1:0] aluOut;
        logic [DATA_W-1:0] readData;
        logic [DATA_W-1:0] pcplus4;
        logic              busErr;
    } memWb_t;

endpackage

// File: rtl/minisys_mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// Latency: n/a (wires only).
// Backpressure: the slave holds off completion by keeping dmem_ack low.
interface minisys_mem_stage_if
    import minisys_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/minisys_load_ext.sv
// Selects the addressed byte/half/word of a read word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none; an all-zero loadType yields zero.
module minisys_load_ext
    import minisys_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [LD_NUM-1:0] loadType,
    output logic [DATA_W-1:0] loadData
);
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane select by offset, then extend according to the one-hot load type
    always_comb begin
        byteSel  = rdata[{off, 3'b000} +: 8];
        halfSel  = off[1] ? rdata[31:16] : rdata[15:0];
        loadData = '0;
        if (loadType[LD_LB])       loadData = {{24{byteSel[7]}}, byteSel};
        else if (loadType[LD_LBU]) loadData = {24'h0, byteSel};
        else if (loadType[LD_LH])  loadData = {{16{halfSel[15]}}, halfSel};
        else if (loadType[LD_LHU]) loadData = {16'h0, halfSel};
        else if (loadType[LD_LW])  loadData = rdata;
    end
endmodule

// File: rtl/minisys_mem_stage.sv
// MiniSys-1A MEM stage: data-memory access, store lane shift, load extract, MEM/WB register.
// Latency: W outputs one cycle after completion; slow memory stalls upstream until ack or TIMEOUT abort.
// Backpressure: stallM held while waiting for dmem_ack; optional MINISYS_MEM_MISALIGN_TRAP_EN adds misalignW.
module minisys_mem_stage
    import minisys_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   validM,
    input  logic                   regwriteM,
    input  logic                   mem2regM,
    input  logic [3:0]             memwriteM,
    input  logic [DATA_W-1:0]      alu_outM,
    input  logic [DATA_W-1:0]      write_dataM,
    input  logic [REG_W-1:0]       write_regM,
    input  logic                   op_lbM,
    input  logic                   op_lbuM,
    input  logic                   op_lhM,
    input  logic                   op_lhuM,
    input  logic                   op_lwM,
    input  logic                   write_$31M,
    input  logic [DATA_W-1:0]      pcplus4M,
    minisys_mem_stage_if.master    dmem,
    output logic                   stallM,
    output logic                   validW,
    output logic                   regwriteW,
    output logic                   mem2regW,
    output logic                   write_$31W,
    output logic [REG_W-1:0]       write_regW,
    output logic [DATA_W-1:0]      alu_outW,
    output logic [DATA_W-1:0]      read_dataW,
    output logic [DATA_W-1:0]      pcplus4W,
    output logic                   bus_errW
`ifdef MINISYS_MEM_MISALIGN_TRAP_EN
    ,output logic                  misalignW
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    memState_t         state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic              access, misalign, reqAccess, cntMax, abort;
    logic [LD_NUM-1:0] loadType;
    logic [DATA_W-1:0] loadData;
    memWb_t            wb;

    assign access = validM & (mem2regM | (|memwriteM)) & ~clr;
    assign cntMax = (cnt == CNT_W'(TIMEOUT));

`ifdef MINISYS_MEM_MISALIGN_TRAP_EN
    logic isHalf, isWord;
    // Half accesses need an even address, word accesses a word-aligned one
    always_comb begin
        isHalf   = mem2regM ? (op_lhM | op_lhuM) : ($countones(memwriteM) == 2);
        isWord   = mem2regM ? op_lwM : (memwriteM == 4'b1111);
        misalign = access & ((isHalf & alu_outM[0]) | (isWord & (alu_outM[1:0] != 2'b00)));
    end
`else
    assign misalign = 1'b0;
`endif

    assign reqAccess = access & ~misalign;

    // State register and saturating wait counter
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            if (nextState == WAIT) begin
                if (state == IDLE)  cnt <= CNT_W'(1);
                else if (!cntMax)   cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Next state: enter WAIT on a missed ack, leave on ack, abort or dropped access
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (reqAccess && !dmem.dmem_ack) nextState = WAIT;
            WAIT: if (!reqAccess || dmem.dmem_ack || cntMax) nextState = IDLE;
        endcase
    end

    // Bus drive, stall and abort decode
    always_comb begin
        dmem.dmem_req   = reqAccess;
        dmem.dmem_we    = reqAccess ? memwriteM : 4'b0000;
        dmem.dmem_addr  = {alu_outM[ADDR_W-1:2], 2'b00};
        dmem.dmem_wdata = write_dataM << {alu_outM[1:0], 3'b000};
        stallM          = 1'b0;
        abort           = 1'b0;
        case (state)
            IDLE: stallM = reqAccess & ~dmem.dmem_ack;
            WAIT: if (reqAccess && !dmem.dmem_ack) begin
                if (cntMax) abort  = 1'b1;
                else        stallM = 1'b1;
            end
        endcase
    end

    // Only a real load selects a lane; everything else reads back as zero
    always_comb begin
        loadType = '0;
        if (validM && mem2regM) begin
            loadType[LD_LB]  = op_lbM;
            loadType[LD_LBU] = op_lbuM;
            loadType[LD_LH]  = op_lhM;
            loadType[LD_LHU] = op_lhuM;
            loadType[LD_LW]  = op_lwM;
        end
    end

    minisys_load_ext uLoadExt (
        .rdata    (dmem.dmem_rdata),
        .off      (alu_outM[1:0]),
        .loadType (loadType),
        .loadData (loadData)
    );

    // MEM/WB register: load on completion, bubble while stalled
    always_ff @(posedge clk) begin
        if (clr) begin
            wb <= '0;
        end else if (stallM) begin
            wb.valid    <= 1'b0;
            wb.regwrite <= 1'b0;
        end else begin
            wb.valid    <= validM;
            wb.regwrite <= regwriteM & ~abort & ~misalign;
            wb.mem2reg  <= mem2regM;
            wb.link     <= write_$31M;
            wb.writeReg <= write_regM;
            wb.aluOut   <= alu_outM;
            wb.readData <= (abort | misalign) ? '0 : loadData;
            wb.pcplus4  <= pcplus4M;
            wb.busErr   <= abort;
        end
    end

`ifdef MINISYS_MEM_MISALIGN_TRAP_EN
    // Misalign flag travels with the MEM/WB bundle
    always_ff @(posedge clk) begin
        if (clr)          misalignW <= 1'b0;
        else if (!stallM) misalignW <= misalign;
    end
`endif

    assign validW     = wb.valid;
    assign regwriteW  = wb.regwrite;
    assign mem2regW   = wb.mem2reg;
    assign write_$31W = wb.link;
    assign write_regW = wb.writeReg;
    assign alu_outW   = wb.aluOut;
    assign read_dataW = wb.readData;
    assign pcplus4W   = wb.pcplus4;
    assign bus_errW   = wb.busErr;
endmodule

// File: tb/tb_minisys_mem_stage.sv
// Scoreboard bench for minisys_mem_stage: directed loads/stores, slow memory, timeout, reset.
// Latency: expected writebacks queued at issue, checked when validW appears.
// Backpressure: driver holds M inputs while stallM is high.
`timescale 1ns/1ps
module tb_minisys_mem_stage;
    import minisys_pkg::*;

    typedef struct {
        logic        regwrite;
        logic        mem2reg;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        busErr;
    } wbExp_t;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } busExp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        validM, regwriteM, mem2regM, linkM;
    logic [3:0]  memwriteM;
    logic [31:0] alu_outM, write_dataM, pcplus4M;
    logic [4:0]  write_regM;
    logic        op_lbM, op_lbuM, op_lhM, op_lhuM, op_lwM;
    logic        stallM, validW, regwriteW, mem2regW, linkW, bus_errW;
    logic [4:0]  write_regW;
    logic [31:0] alu_outW, read_dataW, pcplus4W;
`ifdef MINISYS_MEM_MISALIGN_TRAP_EN
    logic        misalignW;
`endif

    int checks = 0;
    int errors = 0;
    wbExp_t  wbQ[$];
    busExp_t busQ[$];
    logic [31:0] pcNext = 32'h0000_1000;

    minisys_mem_stage_if #(.ADDR_W(32)) dmemIf ();

    minisys_mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .validM      (validM),
        .regwriteM   (regwriteM),
        .mem2regM    (mem2regM),
        .memwriteM   (memwriteM),
        .alu_outM    (alu_outM),
        .write_dataM (write_dataM),
        .write_regM  (write_regM),
        .op_lbM      (op_lbM),
        .op_lbuM     (op_lbuM),
        .op_lhM      (op_lhM),
        .op_lhuM     (op_lhuM),
        .op_lwM      (op_lwM),
        .write_$31M  (linkM),
        .pcplus4M    (pcplus4M),
        .dmem        (dmemIf),
        .stallM      (stallM),
        .validW      (validW),
        .regwriteW   (regwriteW),
        .mem2regW    (mem2regW),
        .write_$31W  (linkW),
        .write_regW  (write_regW),
        .alu_outW    (alu_outW),
        .read_dataW  (read_dataW),
        .pcplus4W    (pcplus4W),
        .bus_errW    (bus_errW)
`ifdef MINISYS_MEM_MISALIGN_TRAP_EN
        ,.misalignW  (misalignW)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every writeback and every completed bus access against the queues
    initial begin
        wbExp_t  w;
        busExp_t b;
        forever begin
            @(negedge clk);
            if (validW === 1'b1) begin
                if (wbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected actual=validW required=none alu=%h", alu_outW);
                end else begin
                    w = wbQ.pop_front();
                    chk("wb_regwrite", {31'h0, regwriteW}, {31'h0, w.regwrite});
                    chk("wb_mem2reg", {31'h0, mem2regW}, {31'h0, w.mem2reg});
                    chk("wb_rd", {27'h0, write_regW}, {27'h0, w.rd});
                    chk("wb_alu", alu_outW, w.alu);
                    chk("wb_rdata", read_dataW, w.rdata);
                    chk("wb_pc", pcplus4W, w.pc);
                    chk("wb_buserr", {31'h0, bus_errW}, {31'h0, w.busErr});
                end
            end
            if (dmemIf.dmem_req === 1'b1 && dmemIf.dmem_ack === 1'b1) begin
                if (busQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected actual=req required=none addr=%h", dmemIf.dmem_addr);
                end else begin
                    b = busQ.pop_front();
                    chk("bus_we", {28'h0, dmemIf.dmem_we}, {28'h0, b.we});
                    chk("bus_addr", dmemIf.dmem_addr, b.addr);
                    chk("bus_wdata", dmemIf.dmem_wdata, b.wdata);
                end
            end
        end
    end

    // Issue one instruction; ackAt = cycle index of ack (-1 = never)
    task automatic issue(input logic isLoad, input logic [4:0] ld, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic rw, input logic [31:0] rdata, input int ackAt,
                         input int expStalls, input logic [31:0] expRead, input logic expErr,
                         input logic [31:0] expWdata);
        wbExp_t  w;
        busExp_t b;
        int      stalls = 0;
        bit      done = 0;
        validM = 1'b1; regwriteM = rw; mem2regM = isLoad; memwriteM = we;
        alu_outM = addr; write_dataM = wdata; write_regM = rd; linkM = 1'b0;
        {op_lwM, op_lhuM, op_lhM, op_lbuM, op_lbM} = ld;
        pcplus4M = pcNext;
        w.regwrite = rw & ~expErr; w.mem2reg = isLoad; w.rd = rd; w.alu = addr;
        w.rdata = expRead; w.pc = pcNext; w.busErr = expErr;
        wbQ.push_back(w);
        if (ackAt >= 0) begin
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.wdata = expWdata;
            busQ.push_back(b);
        end
        pcNext = pcNext + 32'd4;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            dmemIf.dmem_ack   = (cyc == ackAt);
            dmemIf.dmem_rdata = rdata;
            @(negedge clk);
            if (stallM) stalls++;
            if (cyc >= 1 && stallM) chk("bubble_validW", {31'h0, validW}, 32'h0);
            if (!stallM) done = 1;
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=stalled required=complete addr=%h", addr);
        end
        chk("stall_cycles", stalls, expStalls);
        dmemIf.dmem_ack = 1'b0;
        validM = 1'b0; memwriteM = 4'h0; mem2regM = 1'b0;
    endtask

    initial begin
        clr = 1'b1; validM = 1'b1; regwriteM = 1'b1; mem2regM = 1'b1; memwriteM = 4'hF;
        alu_outM = 32'h100; write_dataM = 32'h0; write_regM = 5'd1; linkM = 1'b0;
        {op_lwM, op_lhuM, op_lhM, op_lbuM, op_lbM} = 5'b10000; pcplus4M = 32'h0;
        dmemIf.dmem_ack = 1'b0; dmemIf.dmem_rdata = 32'h0;

        // Reset: requests and stalls gated, W register cleared
        @(negedge clk);
        chk("rst_req", {31'h0, dmemIf.dmem_req}, 32'h0);
        chk("rst_we", {28'h0, dmemIf.dmem_we}, 32'h0);
        chk("rst_stall", {31'h0, stallM}, 32'h0);
        @(posedge clk); #1;
        chk("rst_wb_zero", {validW, regwriteW, mem2regW, linkW, write_regW, bus_errW}, 32'h0);
        chk("rst_wb_data", alu_outW | read_dataW | pcplus4W, 32'h0);
        clr = 1'b0; validM = 1'b0;

        // Bubble: no access, no stall, no writeback
        @(negedge clk);
        chk("bubble_req", {31'h0, dmemIf.dmem_req}, 32'h0);
        chk("bubble_stall", {31'h0, stallM}, 32'h0);
        @(posedge clk); #1;

        //     load ld       we    addr         wdata        rd  rw rdata        ack st expRead      err expWdata
        issue(1, 5'b10000, 4'h0, 32'h100, 32'h0,        5'd2, 1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 32'h0);
        issue(1, 5'b00001, 4'h0, 32'h103, 32'h0,        5'd3, 1, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 32'h0);
        issue(1, 5'b00010, 4'h0, 32'h103, 32'h0,        5'd4, 1, 32'h80FF1234, 0, 0, 32'h00000080, 0, 32'h0);
        issue(1, 5'b00100, 4'h0, 32'h102, 32'h0,        5'd5, 1, 32'h80FF1234, 0, 0, 32'hFFFF80FF, 0, 32'h0);
        issue(1, 5'b01000, 4'h0, 32'h102, 32'h0,        5'd6, 1, 32'h80FF1234, 0, 0, 32'h000080FF, 0, 32'h0);
        issue(1, 5'b00100, 4'h0, 32'h100, 32'h0,        5'd7, 1, 32'h00007FFE, 0, 0, 32'h00007FFE, 0, 32'h0);
        issue(1, 5'b00001, 4'h0, 32'h101, 32'h0,        5'd8, 1, 32'h80FF1234, 0, 0, 32'h00000012, 0, 32'h0);
        issue(0, 5'b00000, 4'h2, 32'h201, 32'h000000AB, 5'd0, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 32'h0000AB00);
        issue(0, 5'b00000, 4'hC, 32'h202, 32'h0000BEEF, 5'd0, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 32'hBEEF0000);
        issue(0, 5'b00000, 4'hF, 32'h300, 32'h12345678, 5'd0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h12345678);
        issue(1, 5'b10000, 4'h0, 32'h104, 32'h0,        5'd9, 1, 32'hCAFEF00D, 2, 2, 32'hCAFEF00D, 0, 32'h0);
        issue(1, 5'b10000, 4'h0, 32'h108, 32'h0,        5'd10, 1, 32'h5555AAAA, -1, 4, 32'h0,      1, 32'h0);
        issue(1, 5'b10000, 4'h0, 32'h10C, 32'h0,        5'd11, 1, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 32'h0);

        // Reset in WAIT: access dropped, no bus error, W cleared
        validM = 1'b1; regwriteM = 1'b1; mem2regM = 1'b1; memwriteM = 4'h0;
        alu_outM = 32'h110; write_regM = 5'd12; {op_lwM, op_lhuM, op_lhM, op_lbuM, op_lbM} = 5'b10000;
        pcplus4M = 32'hABCD0000; dmemIf.dmem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("clrwait_stall", {31'h0, stallM}, 32'h1);
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(negedge clk);
        chk("clr_req", {31'h0, dmemIf.dmem_req}, 32'h0);
        chk("clr_stall", {31'h0, stallM}, 32'h0);
        @(posedge clk); #1;
        clr = 1'b0; validM = 1'b0;
        @(negedge clk);
        chk("clr_wb_zero", {validW, regwriteW, mem2regW, linkW, write_regW, bus_errW}, 32'h0);
        chk("clr_wb_data", alu_outW | read_dataW | pcplus4W, 32'h0);
        chk("clr_req_after", {31'h0, dmemIf.dmem_req}, 32'h0);
        @(posedge clk); #1;
        // FSM must be back in IDLE: a zero-wait load adds no stall
        issue(1, 5'b10000, 4'h0, 32'h114, 32'h0, 5'd13, 1, 32'h600DCAFE, 0, 0, 32'h600DCAFE, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("wbq_drained", wbQ.size(), 32'h0);
        chk("busq_drained", busQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/minisys_mem_stage.md
Name: minisys_mem_stage

Overview:
MEM pipeline stage of the MiniSys-1A CPU. It sits directly downstream of the EXE stage and consumes its M-suffixed outputs. It performs the data-memory access over a req/ack handshake and stalls the pipeline while the memory is slow. It also byte-aligns store data, extracts and extends load data, and registers results into the MEM/WB pipeline register.

Parameters:
TIMEOUT, 16, max WAIT cycles before abort with bus error (>=1)
ADDR_W, 32, data-memory address width

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  synchronous active-high reset
validM  in  1  EXE/MEM register holds a real instruction
regwriteM  in  1  register-file write enable
mem2regM  in  1  instruction is a load
memwriteM  in  4  per-byte store enables, already lane-aligned by address
alu_outM  in  32  effective address / ALU result
write_dataM  in  32  store data (unshifted, in LSBs)
write_regM  in  5  destination register
op_lbM,op_lbuM,op_lhM,op_lhuM,op_lwM  in  1 each  load type (one-hot when mem2regM)
write_$31M  in  1  link write to $31
pcplus4M  in  32  PC+4 for link
dmem_req  out  1  memory request
dmem_we  out  4  byte write enables (0 for loads)
dmem_addr  out  ADDR_W  word-aligned address ({alu_outM[ADDR_W-1:2],2'b00})
dmem_wdata  out  32  lane-shifted store data
dmem_rdata  in  32  read word
dmem_ack  in  1  access complete (may be same cycle as req)
stallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
validW,regwriteW,mem2regW,write_$31W  out  1 each  registered controls
write_regW  out  5  registered destination
alu_outW,read_dataW,pcplus4W  out  32 each  registered data
bus_errW  out  1  registered timeout flag

Behaviour:
- access = validM & (mem2regM | |memwriteM). Access is ignored when clr=1.
- FSM states: IDLE, WAIT. In both states dmem_req=access, dmem_we=memwriteM, dmem_wdata=write_dataM<<(8*alu_outM[1:0]). The address is held stable by the upstream stall.
- IDLE: access & dmem_ack -> complete this cycle, stallM=0, stay IDLE. access & ~dmem_ack -> stallM=1, go WAIT, cnt<=1.
- WAIT: dmem_ack -> complete, stallM=0, go IDLE. ~dmem_ack & cnt==TIMEOUT -> abort: stallM=0, go IDLE, bus_errW<=1, read_dataW<=0, regwriteW<=0. Otherwise stallM=1, cnt<=cnt+1.
- Zero-wait memory (ack same cycle) adds no stall cycles. An N-cycle memory adds N-1 stall cycles.
- MEM/WB register: when stallM=0, all W outputs load from the M inputs and validW<=validM. When stallM=1, validW<=0 and regwriteW<=0 (bubble), so there is no duplicate writeback.
- Load extraction uses dmem_rdata and the off = alu_outM[1:0] captured on completion:
  - lb/lbu: byte off, sign-/zero-extended.
  - lh/lhu: half alu_outM[1], sign-/zero-extended.
  - lw: whole word.
  - non-load: read_dataW=0.
- Stores never set regwriteW unless regwriteM is set; the stage passes regwriteM through unchanged.
- Reset: at the clr edge, state<=IDLE, cnt<=0, and every W output <=0. Combinational dmem_req, dmem_we and stallM are 0 while clr=1. Reset during WAIT aborts the access without a bus error.
- validM=0 -> no req, no stall, a bubble propagates (validW=0).
- cnt width is clog2(TIMEOUT+1). It saturates and never wraps.

Optional Feature:
MINISYS_MEM_MISALIGN_TRAP_EN.
- Defined: lh/lhu/sh with alu_outM[0]=1, or lw/sw with alu_outM[1:0]!=0, is misaligned. A misaligned access suppresses dmem_req, completes in IDLE with no stall, and registers misalignW=1 (extra output port) with regwriteW=0.
- Undefined: no check, port absent, and the address low bits select lanes as above.

Decomposition:
- Shared package minisys_pkg holds:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1)
  - load-type index constants
  - the MEM/WB bundle field widths
- One sub-module, minisys_load_ext: combinational byte/half select plus sign/zero extension, reused by future cache logic.

Test Plan:
- lw at 0x100, zero-wait memory returning 0xDEADBEEF -> stallM never 1, next cycle validW=1, read_dataW=0xDEADBEEF.
- lb at 0x103 with rdata 0x80FF1234 -> read_dataW=0xFFFFFF80. lbu same -> 0x00000080. lh at 0x102 -> 0xFFFF80FF.
- sb at 0x201, write_dataM=0x000000AB, memwriteM=4'b0010 -> dmem_we=4'b0010, dmem_wdata=0x0000AB00, dmem_addr=0x200.
- lw with ack after 3 cycles -> stallM high 2 cycles, validW=0 during stall, one valid writeback after ack.
- No ack with TIMEOUT=4 -> stall 4 cycles, then bus_errW=1, regwriteW=0, FSM back to IDLE.
- clr asserted in WAIT -> next cycle dmem_req=0, stallM=0, all W outputs 0.
